// File: rtl/sigmoid_pkg.sv
// sigmoid_pkg: shared definitions for the sigmoid arbiter slice.
//   - Q-format constants: operands are signed Q6.10, results unsigned Q0.16
//   - arb_state_e: arbiter FSM states
//   - rsp_t: one response entry {id, y} as held in the output FIFO
package sigmoid_pkg;

    localparam int IN_W     = 16;
    localparam int IN_FRAC  = 10;
    localparam int OUT_W    = 16;

    // Widest requester tag (N_REQ up to 16); narrower tags are zero-extended.
    localparam int ID_MAX_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [OUT_W-1:0]    y;
    } rsp_t;

endpackage

// File: rtl/sigmoid_lut.sv
// sigmoid_lut: sigmoid approximation with a combinational address and a
// registered read (y is valid one cycle after x is presented).
// Uses the PLAN piecewise-linear segments, selected from |x|:
//   |x| <  1.0    : 0.25    * |x| + 0.5
//   |x| <  2.375  : 0.125   * |x| + 0.625
//   |x| <  5.0    : 0.03125 * |x| + 0.84375
//   otherwise     : 1.0 (saturates to 0xFFFF)
// Negative inputs use the symmetry sigmoid(-x) = 1 - sigmoid(x).
// Ports:
//   clk  in   rising-edge clock
//   x    in   operand, signed Q6.10
//   y    out  result, unsigned Q0.16, registered
module sigmoid_lut
    import sigmoid_pkg::*;
(
    input  logic             clk,
    input  logic [IN_W-1:0]  x,
    output logic [OUT_W-1:0] y
);

    // Segment breakpoints in Q6.10 and the shifts that turn a Q6.10
    // magnitude times the segment slope into Q0.16.
    localparam logic [IN_W:0] X_ONE  = (IN_W+1)'(1 << IN_FRAC);
    localparam logic [IN_W:0] X_KNEE = (IN_W+1)'((19 << IN_FRAC) >> 3);
    localparam logic [IN_W:0] X_SAT  = (IN_W+1)'(5 << IN_FRAC);
    localparam int SH_SEG1 = 14 - IN_FRAC;
    localparam int SH_SEG2 = 13 - IN_FRAC;
    localparam int SH_SEG3 = 11 - IN_FRAC;

    logic [IN_W:0] x_abs;
    logic [16:0]   y_pos;
    logic [15:0]   y_next;

    always_comb begin
        // One extra bit so that |-32.0| is representable.
        x_abs = x[IN_W-1] ? (~{1'b1, x} + (IN_W+1)'(1)) : {1'b0, x};

        // Each segment's magnitude bound keeps the shifted value inside 17 bits.
        if (x_abs < X_ONE) begin
            y_pos = 17'(x_abs << SH_SEG1) + 17'd32768;
        end else if (x_abs < X_KNEE) begin
            y_pos = 17'(x_abs << SH_SEG2) + 17'd40960;
        end else if (x_abs < X_SAT) begin
            y_pos = 17'(x_abs << SH_SEG3) + 17'd55296;
        end else begin
            y_pos = 17'd65536;
        end

        // y_pos is at least 0.5 here, so 1 - y_pos never underflows.
        if (!x[IN_W-1]) begin
            y_next = y_pos[16] ? 16'hFFFF : y_pos[15:0];
        end else begin
            y_next = 16'(17'd65536 - y_pos);
        end
    end

    always_ff @(posedge clk) begin
        y <= y_next;
    end

endmodule

// File: rtl/sigmoid_arb.sv
// sigmoid_arb: shares one sigmoid_lut among N_REQ requesters with
// round-robin arbitration and a 2-entry in-order response FIFO.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | nothing in flight or queued, no grants; waits for en
// RUN   | grants allowed while en=1 and credit is available
// DRAIN | en dropped: no grants, queued results still pop; IDLE when empty
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   en         in   grant enable; low drains the block
//   req_valid  in   [N_REQ]        per-requester request valid
//   req_ready  out  [N_REQ]        per-requester accept, one-hot or zero
//   req_x      in   [N_REQ*IN_W]   operands, requester i at [i*IN_W +: IN_W]
//   rsp_valid  out  result available
//   rsp_ready  in   consumer accept
//   rsp_id     out  [ID_W]   originating requester
//   rsp_y      out  [OUT_W]  sigmoid result, Q0.16
//   busy       out  high whenever the FSM is not in IDLE
//   stall_cnt  out  [32]         only with SIGMOID_ARB_STATS_EN: saturating
//                                count of RUN cycles with a request but no grant
//   grant_cnt  out  [N_REQ*16]   only with SIGMOID_ARB_STATS_EN: saturating
//                                per-requester accept counters
//
// The LUT implements the package Q formats; IN_W/OUT_W must stay at 16.
module sigmoid_arb
    import sigmoid_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*IN_W-1:0] req_x,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [OUT_W-1:0]      rsp_y,
    output logic                  busy
`ifdef SIGMOID_ARB_STATS_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [N_REQ*16-1:0]   grant_cnt
`endif
);

    localparam int             IDX_W   = ID_W + 1;
    localparam logic [ID_W:0]  N_REQ_W = IDX_W'(N_REQ);

    arb_state_e        state;
    arb_state_e        state_next;
    logic [ID_W-1:0]   last_grant;
    logic              inflight;
    logic [ID_W-1:0]   inflight_id;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_ok;
    logic              grant_any;
    logic [2:0]        credit;

    logic [IN_W-1:0]   lut_x;
    logic [OUT_W-1:0]  lut_y;

    rsp_t              fifo_mem [2];
    logic              fifo_wr_ptr;
    logic              fifo_rd_ptr;
    logic [1:0]        fifo_count;
    rsp_t              fifo_head;
    rsp_t              push_entry;
    logic              push;
    logic              pop;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (en) state_next = RUN;
            end
            RUN: begin
                if (!en) state_next = DRAIN;
            end
            DRAIN: begin
                if (en) begin
                    state_next = RUN;
                end else if (!inflight && (fifo_count == 2'd0)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // ------------------------------------------------- round-robin picker
    always_comb begin
        logic [ID_W:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, last_grant} + IDX_W'(k);
            if (cand >= N_REQ_W) cand = cand - N_REQ_W;
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    // Credit counts FIFO slots still free once everything already granted
    // has landed. The pop term lets a full pipeline keep one accept per
    // cycle while the consumer is taking results; it is the only path from
    // rsp_ready to req_ready.
    assign pop      = rsp_valid & rsp_ready;
    assign credit   = 3'd2 + {2'b0, pop} - {2'b0, inflight} - {1'b0, fifo_count};
    assign grant_ok = (state == RUN) && en && (credit != 3'd0);
    assign grant_any = grant_ok && grant_found;

    always_comb begin
        req_ready = '0;
        if (grant_any) req_ready[grant_idx] = 1'b1;
    end

    // ------------------------------------------------------- shared LUT
    always_comb begin
        lut_x = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == ID_W'(i)) lut_x = req_x[i*IN_W +: IN_W];
        end
    end

    sigmoid_lut u_lut (
        .clk (clk),
        .x   (lut_x),
        .y   (lut_y)
    );

    // The tag travels one cycle alongside the registered LUT read.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant  <= ID_W'(N_REQ - 1);
            inflight    <= 1'b0;
            inflight_id <= '0;
        end else begin
            if (grant_any) last_grant <= grant_idx;
            inflight    <= grant_any;
            inflight_id <= grant_idx;
        end
    end

    // -------------------------------------------------- 2-entry out FIFO
    assign push = inflight;

    always_comb begin
        push_entry    = '0;
        push_entry.id = ID_MAX_W'(inflight_id);
        push_entry.y  = lut_y;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[fifo_wr_ptr] <= push_entry;
                fifo_wr_ptr           <= ~fifo_wr_ptr;
            end
            if (pop) fifo_rd_ptr <= ~fifo_rd_ptr;
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

    // The head entry only changes on a pop, so outputs hold under backpressure.
    assign fifo_head = fifo_mem[fifo_rd_ptr];
    assign rsp_valid = (fifo_count != 2'd0);
    assign rsp_id    = rsp_valid ? ID_W'(fifo_head.id) : '0;
    assign rsp_y     = rsp_valid ? fifo_head.y : '0;

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (fifo_count == 2'd2)));

    a_ready_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_ready));

    // -------------------------------------------------------- statistics
`ifdef SIGMOID_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            grant_cnt <= '0;
        end else begin
            if ((state == RUN) && (|req_valid) && !grant_any
                && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && req_ready[i]
                    && (grant_cnt[i*16 +: 16] != 16'hFFFF)) begin
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_sigmoid_arb.sv
// tb_sigmoid_arb: directed self-checking bench for sigmoid_arb.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
module tb_sigmoid_arb;

    localparam int N_REQ = 4;
    localparam int IN_W  = 16;
    localparam int OUT_W = 16;
    localparam int ID_W  = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*IN_W-1:0] req_x;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [OUT_W-1:0]      rsp_y;
    logic                  busy;
`ifdef SIGMOID_ARB_STATS_EN
    logic [31:0]           stall_cnt;
    logic [N_REQ*16-1:0]   grant_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sigmoid_arb #(
        .N_REQ (N_REQ),
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .busy      (busy)
`ifdef SIGMOID_ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .grant_cnt (grant_cnt)
`endif
    );

    // Single-requester vectors: {id, x (Q6.10), expected y (Q0.16)}.
    int          vec_id [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    logic [15:0] vec_x  [12] = '{16'h0400, 16'hFC00, 16'h1400, 16'hEC00,
                                 16'h0800, 16'h0C00, 16'h8000, 16'h7FFF,
                                 16'hFFFF, 16'h0001, 16'h0980, 16'h0000};
    logic [15:0] vec_y  [12] = '{16'hC000, 16'h4000, 16'hFFFF, 16'h0000,
                                 16'hE000, 16'hF000, 16'h0000, 16'hFFFF,
                                 16'h7FF0, 16'h8010, 16'hEB00, 16'h8000};

    // Per-requester operands for the all-requesters tests, and their results.
    logic [N_REQ*IN_W-1:0] fair_x = {16'h1400, 16'hFC00, 16'h0400, 16'h0000};
    logic [15:0]           fair_y [4] = '{16'h8000, 16'hC000, 16'h4000, 16'hFFFF};

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        int acc;
        logic [3:0] exp_ready;

        rst       = 1'b1;
        en        = 1'b1;
        req_valid = '0;
        req_x     = '0;
        rsp_ready = 1'b0;

        // ---- reset
        cyc();
        cyc();
        settle();
        check_val("rst_req_ready", 32'(req_ready), 32'h0);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check_val("rst_rsp_id",    32'(rsp_id),    32'h0);
        check_val("rst_rsp_y",     32'(rsp_y),     32'h0);
        check_val("rst_busy",      32'(busy),      32'h0);

        cyc();
        rst = 1'b0;
        settle();
        check_val("rel_idle_busy", 32'(busy), 32'h0);
        cyc();
        settle();
        check_val("rel_run_busy", 32'(busy), 32'h1);

        // ---- single request from requester 2, x = 0
        cyc();
        req_valid = 4'b0100;
        req_x     = '0;
        rsp_ready = 1'b1;
        settle();
        check_val("single_ready", 32'(req_ready), 32'h4);
        cyc();
        req_valid = '0;
        settle();
        check_val("single_t1_valid", 32'(rsp_valid), 32'h0);
        cyc();
        settle();
        check_val("single_t2_valid", 32'(rsp_valid), 32'h1);
        check_val("single_t2_id",    32'(rsp_id),    32'h2);
        check_val("single_t2_y",     32'(rsp_y),     32'h8000);

        // ---- back-to-back single requests across LUT segments
        for (int c = 0; c < 14; c++) begin
            cyc();
            if (c < 12) begin
                req_valid = 4'b0001 << vec_id[c];
                req_x     = '0;
                req_x[vec_id[c]*IN_W +: IN_W] = vec_x[c];
            end else begin
                req_valid = '0;
            end
            settle();
            if (c < 12) check_val("stream_ready", 32'(req_ready), 32'(4'b0001 << vec_id[c]));
            if (c >= 2) begin
                check_val("stream_rsp_valid", 32'(rsp_valid), 32'h1);
                check_val("stream_rsp_id",    32'(rsp_id),    32'(vec_id[c-2]));
                check_val("stream_rsp_y",     32'(rsp_y),     32'(vec_y[c-2]));
            end
        end

        // ---- fairness: all requesters pending, consumer always ready
        req_x = fair_x;
        for (int c = 0; c < 10; c++) begin
            cyc();
            req_valid = (c < 8) ? 4'hF : 4'h0;
            settle();
            if (c < 8) check_val("fair_ready", 32'(req_ready), 32'(4'b0001 << (c % 4)));
            if (c >= 2) begin
                check_val("fair_rsp_valid", 32'(rsp_valid), 32'h1);
                check_val("fair_rsp_id",    32'(rsp_id),    32'((c - 2) % 4));
                check_val("fair_rsp_y",     32'(rsp_y),     32'(fair_y[(c - 2) % 4]));
            end
        end

        // ---- backpressure: consumer stalled, all requesters pending
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            rsp_ready = 1'b0;
            req_valid = 4'hF;
            settle();
            if (req_ready != 4'h0) acc++;
            exp_ready = (c == 0) ? 4'b0001 : (c == 1) ? 4'b0010 : 4'b0000;
            check_val("bp_ready", 32'(req_ready), 32'(exp_ready));
            if (c >= 2) begin
                check_val("bp_hold_valid", 32'(rsp_valid), 32'h1);
                check_val("bp_hold_id",    32'(rsp_id),    32'h0);
                check_val("bp_hold_y",     32'(rsp_y),     32'h8000);
            end
        end
        check_val("bp_accepts", 32'(acc), 32'd2);
        cyc();
        rsp_ready = 1'b1;
        req_valid = '0;
        settle();
        check_val("bp_pop0_valid", 32'(rsp_valid), 32'h1);
        check_val("bp_pop0_id",    32'(rsp_id),    32'h0);
        check_val("bp_pop0_y",     32'(rsp_y),     32'h8000);
        cyc();
        settle();
        check_val("bp_pop1_valid", 32'(rsp_valid), 32'h1);
        check_val("bp_pop1_id",    32'(rsp_id),    32'h1);
        check_val("bp_pop1_y",     32'(rsp_y),     32'hC000);
        cyc();
        settle();
        check_val("bp_empty", 32'(rsp_valid), 32'h0);

        // ---- drain: en drops with one result in flight and one queued
        cyc();
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        settle();
        check_val("drain_g2", 32'(req_ready), 32'h4);
        cyc();
        settle();
        check_val("drain_g3", 32'(req_ready), 32'h8);
        cyc();
        en = 1'b0;
        settle();
        check_val("drain_en0_ready", 32'(req_ready), 32'h0);
        check_val("drain_en0_busy",  32'(busy),      32'h1);
        cyc();
        rsp_ready = 1'b1;
        settle();
        check_val("drain_d3_ready", 32'(req_ready), 32'h0);
        check_val("drain_d3_busy",  32'(busy),      32'h1);
        check_val("drain_d3_valid", 32'(rsp_valid), 32'h1);
        check_val("drain_d3_id",    32'(rsp_id),    32'h2);
        check_val("drain_d3_y",     32'(rsp_y),     32'h4000);
        cyc();
        settle();
        check_val("drain_d4_ready", 32'(req_ready), 32'h0);
        check_val("drain_d4_busy",  32'(busy),      32'h1);
        check_val("drain_d4_id",    32'(rsp_id),    32'h3);
        check_val("drain_d4_y",     32'(rsp_y),     32'hFFFF);
        cyc();
        settle();
        check_val("drain_d5_valid", 32'(rsp_valid), 32'h0);
        cyc();
        settle();
        check_val("drain_idle_busy",  32'(busy),      32'h0);
        check_val("drain_idle_ready", 32'(req_ready), 32'h0);

        // ---- en gating in RUN, and DRAIN returning to RUN
        cyc();
        en = 1'b1;
        settle();
        check_val("en_idle_ready", 32'(req_ready), 32'h0);
        cyc();
        en = 1'b0;
        settle();
        check_val("en_run_busy",  32'(busy),      32'h1);
        check_val("en_run_ready", 32'(req_ready), 32'h0);
        cyc();
        en = 1'b1;
        settle();
        check_val("en_drain_busy",  32'(busy),      32'h1);
        check_val("en_drain_ready", 32'(req_ready), 32'h0);
        cyc();
        settle();
        check_val("en_rerun_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid = '0;
        settle();
        cyc();
        settle();
        check_val("en_rerun_id", 32'(rsp_id), 32'h0);
        check_val("en_rerun_y",  32'(rsp_y),  32'h8000);
        cyc();
        settle();

        // ---- reset with a full FIFO
        cyc();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        settle();
        check_val("mr_g1", 32'(req_ready), 32'h2);
        cyc();
        settle();
        check_val("mr_g2", 32'(req_ready), 32'h4);
        cyc();
        settle();
        cyc();
        settle();
        check_val("mr_full_valid", 32'(rsp_valid), 32'h1);
        check_val("mr_full_ready", 32'(req_ready), 32'h0);
        check_val("mr_full_id",    32'(rsp_id),    32'h1);
        cyc();
        rst = 1'b1;
        settle();
        cyc();
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        settle();
        check_val("mr_valid", 32'(rsp_valid), 32'h0);
        check_val("mr_busy",  32'(busy),      32'h0);
        check_val("mr_id",    32'(rsp_id),    32'h0);
        check_val("mr_y",     32'(rsp_y),     32'h0);
`ifdef SIGMOID_ARB_STATS_EN
        check_val("mr_stall_cnt", stall_cnt, 32'h0);
        check_val("mr_grant_cnt", 32'(|grant_cnt), 32'h0);
`endif
        for (int c = 0; c < 4; c++) begin
            cyc();
            settle();
            check_val("mr_no_stale", 32'(rsp_valid), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
